exu_stage: RTL and testbench

- Execute-stage wrapper that owns pipeline state around the combinational ALU.
- Accepts decoded uops plus operands from ID over a valid/ready handshake, holds them in an E1 register, and drives the ALU from E1.
- Captures the ALU result into an E2 output register for LSU/WB.
- Resolves branches and jumps into a registered one-cycle redirect pulse toward IF/ID.

---
 rtl/liang_pkg.sv | 54 +++++
 rtl/exu_stage_if.sv | 38 +++
 rtl/alu.sv | 84 ++++++++
 rtl/exu_stage.sv | 196 +++++++++++++++++++
 tb/tb_exu_stage.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/liang_pkg.sv
// liang_pkg: shared types for the execute stage.
// Holds XLEN, the functional-unit opcode/function enums, the decoded uop
// struct handed from ID to EX, and the is_jump helper.
package liang_pkg;

    localparam int unsigned XLEN = 32;

    // Coarse functional-unit class chosen by the decoder.
    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,  // reg-reg arithmetic/logic
        FU_ALUI   = 3'd1,  // reg-imm arithmetic/logic
        FU_BRANCH = 3'd2,  // conditional branch
        FU_JAL    = 3'd3,  // pc-relative jump and link
        FU_JALR   = 3'd4,  // register-indirect jump and link
        FU_LOAD   = 3'd5,  // address generation for loads
        FU_STORE  = 3'd6   // address generation for stores
    } fu_op_e;

    // Operation selector inside the functional unit.
    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_SLL  = 4'd2,
        FN_SLT  = 4'd3,
        FN_SLTU = 4'd4,
        FN_XOR  = 4'd5,
        FN_SRL  = 4'd6,
        FN_SRA  = 4'd7,
        FN_OR   = 4'd8,
        FN_AND  = 4'd9,
        FN_EQ   = 4'd10,
        FN_NE   = 4'd11,
        FN_LT   = 4'd12,
        FN_GE   = 4'd13,
        FN_LTU  = 4'd14,
        FN_GEU  = 4'd15
    } fu_func_e;

    // Decoded uop carried through E1 and E2.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fu_op_e          fu_op;
        fu_func_e        fu_func;
        logic [4:0]      rd;
        logic            rd_wen;
    } uop_info_t;

    // Unconditional jumps always redirect when they leave E1.
    function automatic logic is_jump(input fu_op_e op);
        return (op == FU_JAL) || (op == FU_JALR);
    endfunction

endpackage

// File: rtl/exu_stage_if.sv
// exu_stage_if: bundles the ID->EX request channel and the EX->LSU/WB
// result channel of the execute stage.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. The source holds valid and its payload stable until
// that edge; ready may rise and fall freely and never waits on valid
// from the same channel's source.
interface exu_stage_if;
    import liang_pkg::*;

    logic            id_valid;
    logic            id_ready;
    uop_info_t       id_uop;
    logic [XLEN-1:0] id_rs1;
    logic [XLEN-1:0] id_rs2;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_res;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_rd_wen;
    uop_info_t       ex_uop;
    logic [XLEN-1:0] ex_rs2;

    // Environment side: produces uops from ID and consumes results.
    modport master (
        output id_valid, id_uop, id_rs1, id_rs2, ex_ready,
        input  id_ready, ex_valid, ex_res, ex_pc, ex_rd, ex_rd_wen, ex_uop, ex_rs2
    );

    // Execute-stage side.
    modport slave (
        input  id_valid, id_uop, id_rs1, id_rs2, ex_ready,
        output id_ready, ex_valid, ex_res, ex_pc, ex_rd, ex_rd_wen, ex_uop, ex_rs2
    );

endinterface

// File: rtl/alu.sv
// alu: combinational functional unit driven from the E1 register.
// Produces the integer result (arithmetic, address or link value) and
// the branch-condition outcome.
module alu
    import liang_pkg::*;
(
    input  fu_op_e          fu_op_i,
    input  fu_func_e        fu_func_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] res_o,
    output logic            jump_o
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    fu_func_e        fn;
    logic [4:0]      shamt;
    logic            eq;
    logic            lt_s;
    logic            lt_u;

    // Operand and operation selection: addresses and link values reuse the adder.
    always_comb begin
        op_a = rs1_i;
        op_b = rs2_i;
        fn   = fu_func_i;
        case (fu_op_i)
            FU_ALUI: op_b = imm_i;
            FU_LOAD, FU_STORE: begin
                op_b = imm_i;
                fn   = FN_ADD;
            end
            FU_JAL, FU_JALR: begin
                op_a = pc_i;
                op_b = XLEN'(4);
                fn   = FN_ADD;
            end
            default: ;
        endcase
    end

    assign shamt = op_b[4:0];
    assign eq    = (rs1_i == rs2_i);
    assign lt_s  = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u  = (rs1_i < rs2_i);

    // Result datapath; compare-only functions (branches) yield zero.
    always_comb begin
        res_o = '0;
        case (fn)
            FN_ADD:  res_o = op_a + op_b;
            FN_SUB:  res_o = op_a - op_b;
            FN_SLL:  res_o = op_a << shamt;
            FN_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            FN_SLTU: res_o = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            FN_XOR:  res_o = op_a ^ op_b;
            FN_SRL:  res_o = op_a >> shamt;
            FN_SRA:  res_o = $signed(op_a) >>> shamt;
            FN_OR:   res_o = op_a | op_b;
            FN_AND:  res_o = op_a & op_b;
            default: res_o = '0;
        endcase
    end

    // Branch condition, only meaningful for FU_BRANCH uops.
    always_comb begin
        jump_o = 1'b0;
        if (fu_op_i == FU_BRANCH) begin
            case (fu_func_i)
                FN_EQ:   jump_o = eq;
                FN_NE:   jump_o = ~eq;
                FN_LT:   jump_o = lt_s;
                FN_GE:   jump_o = ~lt_s;
                FN_LTU:  jump_o = lt_u;
                FN_GEU:  jump_o = ~lt_u;
                default: jump_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/exu_stage.sv
// exu_stage: execute-stage wrapper around the ALU.
// E1 holds the accepted uop and operands and feeds the ALU; E2 registers
// the result for LSU/WB. Taken branches and jumps leaving E1 produce a
// registered one-cycle redirect toward IF/ID.
// Optional macro EXU_MISALIGN_CHK_EN adds a misaligned-target flag that
// accompanies the redirect pulse; without it misalign_o is tied to 0.
module exu_stage
    import liang_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  uop_info_t       id_uop_i,
    input  logic [XLEN-1:0] id_rs1_i,
    input  logic [XLEN-1:0] id_rs2_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_res_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_rd_wen_o,
    output uop_info_t       ex_uop_o,
    output logic [XLEN-1:0] ex_rs2_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            misalign_o
);

    logic            e1_valid_q, e1_valid_d;
    uop_info_t       e1_uop_q,   e1_uop_d;
    logic [XLEN-1:0] e1_rs1_q,   e1_rs1_d;
    logic [XLEN-1:0] e1_rs2_q,   e1_rs2_d;

    logic            e2_valid_q,  e2_valid_d;
    uop_info_t       e2_uop_q,    e2_uop_d;
    logic [XLEN-1:0] e2_res_q,    e2_res_d;
    logic [XLEN-1:0] e2_rs2_q,    e2_rs2_d;
    logic            e2_rd_wen_q, e2_rd_wen_d;

    logic            rdr_valid_q, rdr_valid_d;
    logic [XLEN-1:0] rdr_pc_q,    rdr_pc_d;

    logic            e2_adv;
    logic            e1_free;
    logic            id_fire;
    logic            e2_load;
    logic            is_branch;
    logic            take;
    logic [XLEN-1:0] alu_res;
    logic            alu_jump;
    logic [XLEN-1:0] tgt_base;
    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] target;

    alu u_alu (
        .fu_op_i   (e1_uop_q.fu_op),
        .fu_func_i (e1_uop_q.fu_func),
        .pc_i      (e1_uop_q.pc),
        .imm_i     (e1_uop_q.imm),
        .rs1_i     (e1_rs1_q),
        .rs2_i     (e1_rs2_q),
        .res_o     (alu_res),
        .jump_o    (alu_jump)
    );

    // Pipeline advance. During a redirect cycle E1 holds a wrong-path uop,
    // so it must not move into E2 even when E2 has room.
    assign e2_adv     = e1_valid_q & (~e2_valid_q | ex_ready_i);
    assign e1_free    = ~e1_valid_q | e2_adv;
    assign id_ready_o = e1_free & ~rdr_valid_q & ~flush_i;
    assign id_fire    = id_valid_i & id_ready_o;
    assign e2_load    = e2_adv & ~rdr_valid_q & ~flush_i;

    assign is_branch = (e1_uop_q.fu_op == FU_BRANCH);
    assign take      = e2_load & (is_branch ? alu_jump : is_jump(e1_uop_q.fu_op));

    // Dedicated target adder; JALR clears bit 0 of the sum.
    always_comb begin
        tgt_base = e1_uop_q.pc;
        if (e1_uop_q.fu_op == FU_JALR) begin
            tgt_base = e1_rs1_q;
        end
    end

    assign tgt_sum = tgt_base + e1_uop_q.imm;
    assign target  = (e1_uop_q.fu_op == FU_JALR) ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

    // Next-state for E1, E2 and the redirect register; flush beats everything.
    always_comb begin
        e1_valid_d  = e1_valid_q;
        e1_uop_d    = e1_uop_q;
        e1_rs1_d    = e1_rs1_q;
        e1_rs2_d    = e1_rs2_q;
        e2_valid_d  = e2_valid_q;
        e2_uop_d    = e2_uop_q;
        e2_res_d    = e2_res_q;
        e2_rs2_d    = e2_rs2_q;
        e2_rd_wen_d = e2_rd_wen_q;
        rdr_valid_d = take;
        rdr_pc_d    = rdr_pc_q;

        if (id_fire) begin
            e1_uop_d = id_uop_i;
            e1_rs1_d = id_rs1_i;
            e1_rs2_d = id_rs2_i;
        end

        if (flush_i || rdr_valid_q) begin
            e1_valid_d = 1'b0;
        end else if (id_fire) begin
            e1_valid_d = 1'b1;
        end else if (e2_load) begin
            e1_valid_d = 1'b0;
        end

        if (e2_load) begin
            e2_uop_d    = e1_uop_q;
            e2_res_d    = alu_res;
            e2_rs2_d    = e1_rs2_q;
            e2_rd_wen_d = e1_uop_q.rd_wen & ~is_branch & (e1_uop_q.fu_op != FU_STORE);
        end

        if (flush_i) begin
            e2_valid_d = 1'b0;
        end else if (e2_load) begin
            e2_valid_d = 1'b1;
        end else if (ex_ready_i) begin
            e2_valid_d = 1'b0;
        end

        if (take) begin
            rdr_pc_d = target;
        end
    end

    // Pipeline and redirect registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e1_valid_q  <= 1'b0;
            e1_uop_q    <= '0;
            e1_rs1_q    <= '0;
            e1_rs2_q    <= '0;
            e2_valid_q  <= 1'b0;
            e2_uop_q    <= '0;
            e2_res_q    <= '0;
            e2_rs2_q    <= '0;
            e2_rd_wen_q <= 1'b0;
            rdr_valid_q <= 1'b0;
            rdr_pc_q    <= '0;
        end else begin
            e1_valid_q  <= e1_valid_d;
            e1_uop_q    <= e1_uop_d;
            e1_rs1_q    <= e1_rs1_d;
            e1_rs2_q    <= e1_rs2_d;
            e2_valid_q  <= e2_valid_d;
            e2_uop_q    <= e2_uop_d;
            e2_res_q    <= e2_res_d;
            e2_rs2_q    <= e2_rs2_d;
            e2_rd_wen_q <= e2_rd_wen_d;
            rdr_valid_q <= rdr_valid_d;
            rdr_pc_q    <= rdr_pc_d;
        end
    end

`ifdef EXU_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = take & (target[1:0] != 2'b00);

    // Misalignment flag registered alongside the redirect pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign ex_valid_o       = e2_valid_q;
    assign ex_res_o         = e2_res_q;
    assign ex_pc_o          = e2_uop_q.pc;
    assign ex_rd_o          = e2_uop_q.rd;
    assign ex_rd_wen_o      = e2_rd_wen_q;
    assign ex_uop_o         = e2_uop_q;
    assign ex_rs2_o         = e2_rs2_q;
    assign redirect_valid_o = rdr_valid_q;
    assign redirect_pc_o    = rdr_pc_q;

endmodule

// File: tb/tb_exu_stage.sv
// tb_exu_stage: directed scoreboard bench for exu_stage.
// Accepted uops push their expected result; a monitor pops on every
// E2 handshake and every redirect pulse.
module tb_exu_stage;
    import liang_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            misalign;
    int              cyc = 0;

    exu_stage_if bus();

    exu_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .id_valid_i       (bus.id_valid),
        .id_ready_o       (bus.id_ready),
        .id_uop_i         (bus.id_uop),
        .id_rs1_i         (bus.id_rs1),
        .id_rs2_i         (bus.id_rs2),
        .ex_valid_o       (bus.ex_valid),
        .ex_ready_i       (bus.ex_ready),
        .ex_res_o         (bus.ex_res),
        .ex_pc_o          (bus.ex_pc),
        .ex_rd_o          (bus.ex_rd),
        .ex_rd_wen_o      (bus.ex_rd_wen),
        .ex_uop_o         (bus.ex_uop),
        .ex_rs2_o         (bus.ex_rs2),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .misalign_o       (misalign)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] rs2;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
    } rdr_t;

    exp_t exp_q[$];
    rdr_t rdr_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic uop_info_t mk(input fu_op_e op, input fu_func_e fn, input logic [31:0] pc,
                                     input logic [31:0] imm, input logic [4:0] rd, input logic wen);
        uop_info_t u;
        u.pc = pc; u.imm = imm; u.fu_op = op; u.fu_func = fn; u.rd = rd; u.rd_wen = wen;
        return u;
    endfunction

    // Present a uop from a negedge until accepted; record expectations at acceptance.
    task automatic issue(input uop_info_t u, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_out, input logic [31:0] exp_res,
                         input bit exp_rdr, input logic [31:0] exp_tgt);
        bit   done = 1'b0;
        exp_t e;
        rdr_t r;
        bus.id_valid = 1'b1;
        bus.id_uop   = u;
        bus.id_rs1   = a;
        bus.id_rs2   = b;
        for (int t = 0; t < 40 && !done; t++) begin
            #1;
            if (bus.id_ready) begin
                done = 1'b1;
                if (exp_out) begin
                    e.res    = exp_res;
                    e.pc     = u.pc;
                    e.rd     = u.rd;
                    e.rd_wen = u.rd_wen && (u.fu_op != FU_BRANCH) && (u.fu_op != FU_STORE);
                    e.rs2    = b;
                    exp_q.push_back(e);
                end
                if (exp_rdr) begin
                    r.pc = exp_tgt;
`ifdef EXU_MISALIGN_CHK_EN
                    r.mis = (exp_tgt[1:0] != 2'b00);
`else
                    r.mis = 1'b0;
`endif
                    rdr_q.push_back(r);
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: pc 0x%08h never accepted", u.pc);
        end
    endtask

    task automatic idle(input int n);
        bus.id_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares E2 handshakes and redirect pulses just before each posedge.
    initial begin
        exp_t e;
        rdr_t r;
        bit   prev_rdr = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (bus.ex_valid && bus.ex_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: pc 0x%08h res 0x%08h, no result expected", bus.ex_pc, bus.ex_res);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ex_res !== e.res || bus.ex_pc !== e.pc || bus.ex_rd !== e.rd ||
                        bus.ex_rd_wen !== e.rd_wen || bus.ex_rs2 !== e.rs2) begin
                        n_fail++;
                        $display("FAIL result: got res 0x%08h pc 0x%08h rd %0d wen %0b rs2 0x%08h, expected res 0x%08h pc 0x%08h rd %0d wen %0b rs2 0x%08h",
                                 bus.ex_res, bus.ex_pc, bus.ex_rd, bus.ex_rd_wen, bus.ex_rs2,
                                 e.res, e.pc, e.rd, e.rd_wen, e.rs2);
                    end
                end
            end
            if (redirect_valid) begin
                n_tests++;
                if (prev_rdr) begin
                    n_fail++;
                    $display("FAIL redirect_width: pulse pc 0x%08h longer than one cycle", redirect_pc);
                end else if (rdr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_redirect: pc 0x%08h, no redirect expected", redirect_pc);
                end else begin
                    r = rdr_q.pop_front();
                    if (redirect_pc !== r.pc || misalign !== r.mis || bus.id_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL redirect: got pc 0x%08h mis %0b id_ready %0b, expected pc 0x%08h mis %0b id_ready 0",
                                 redirect_pc, misalign, bus.id_ready, r.pc, r.mis);
                    end
                end
            end else if (misalign) begin
                n_tests++;
                n_fail++;
                $display("FAIL misalign_alone: got 1 expected 0 without redirect");
            end
            prev_rdr = redirect_valid;
        end
    end

    // Watchdog bound on the whole run.
    initial begin
        #50000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int c0;
        rst          = 1'b1;
        flush        = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_uop   = '0;
        bus.id_rs1   = '0;
        bus.id_rs2   = '0;
        bus.ex_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_ex_res", bus.ex_res, 0);
        chk("rst_ex_pc", bus.ex_pc, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_rd_wen", bus.ex_rd_wen, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADDI with two-cycle latency.
        issue(mk(FU_ALUI, FN_ADD, 32'h8000_0000, 32'd7, 5'd1, 1'b1), 32'd5, 32'd0, 1, 32'd12, 0, 0);
        bus.id_valid = 1'b0;
        #1 chk("addi_lat_1cyc", bus.ex_valid, 0);
        @(negedge clk);
        #1;
        chk("addi_lat_2cyc", bus.ex_valid, 1);
        chk("addi_res", bus.ex_res, 32'd12);
        chk("addi_rd_wen", bus.ex_rd_wen, 1);
        idle(3);

        // Back-to-back mix, one uop per cycle.
        c0 = cyc;
        issue(mk(FU_ALU,   FN_SUB,  32'h1000, 32'h0,        5'd2, 1'b1), 32'd10,        32'd15,        1, 32'hFFFF_FFFB, 0, 0);
        issue(mk(FU_ALU,   FN_SLL,  32'h1004, 32'h0,        5'd3, 1'b1), 32'd1,         32'd31,        1, 32'h8000_0000, 0, 0);
        issue(mk(FU_ALU,   FN_SLT,  32'h1008, 32'h0,        5'd4, 1'b1), 32'hFFFF_FFFE, 32'd1,         1, 32'd1,         0, 0);
        issue(mk(FU_ALU,   FN_SLTU, 32'h100C, 32'h0,        5'd5, 1'b1), 32'hFFFF_FFFE, 32'd1,         1, 32'd0,         0, 0);
        issue(mk(FU_ALU,   FN_SRA,  32'h1010, 32'h0,        5'd6, 1'b1), 32'h8000_0000, 32'd4,         1, 32'hF800_0000, 0, 0);
        issue(mk(FU_STORE, FN_ADD,  32'h1014, 32'h10,       5'd7, 1'b1), 32'h100,       32'hDEAD_BEEF, 1, 32'h110,       0, 0);
        issue(mk(FU_LOAD,  FN_ADD,  32'h1018, 32'hFFFF_FFFC, 5'd8, 1'b1), 32'h200,      32'd0,         1, 32'h1FC,       0, 0);
        issue(mk(FU_ALUI,  FN_XOR,  32'h101C, 32'h0F0F_0F0F, 5'd9, 1'b1), 32'hFF00_FF00, 32'd0,        1, 32'hF00F_F00F, 0, 0);
        chk("b2b_cycles", cyc - c0, 8);
        idle(4);

        // Taken BEQ; the following ADDI is wrong-path.
        issue(mk(FU_BRANCH, FN_EQ,  32'h100, 32'h20, 5'd0, 1'b1), 32'd3, 32'd3, 1, 32'd0, 1, 32'h120);
        issue(mk(FU_ALUI,   FN_ADD, 32'h104, 32'd1,  5'd1, 1'b1), 32'd0, 32'd0, 0, 32'd0, 0, 0);
        idle(4);

        // Not-taken BNE then BGEU, with a younger ADDI that must complete.
        issue(mk(FU_BRANCH, FN_NE,   32'h180, 32'h40, 5'd0, 1'b0), 32'd3, 32'd3,         1, 32'd0, 0, 0);
        issue(mk(FU_BRANCH, FN_GEU,  32'h184, 32'h40, 5'd0, 1'b0), 32'd1, 32'hFFFF_FFFF, 1, 32'd0, 0, 0);
        issue(mk(FU_ALUI,   FN_ADD,  32'h188, 32'd9,  5'd3, 1'b1), 32'd1, 32'd0,         1, 32'd10, 0, 0);
        idle(4);

        // Jumps and a taken signed branch, each followed by idle cycles.
        issue(mk(FU_JALR,   FN_ADD, 32'h40, 32'd4, 5'd1, 1'b1), 32'h2001, 32'd0, 1, 32'h44, 1, 32'h2004);
        idle(4);
        issue(mk(FU_JALR,   FN_ADD, 32'h48, 32'd0, 5'd1, 1'b1), 32'h2003, 32'd0, 1, 32'h4C, 1, 32'h2002);
        idle(4);
        issue(mk(FU_JAL,    FN_ADD, 32'h200, 32'h10, 5'd1, 1'b1), 32'd0, 32'd0, 1, 32'h204, 1, 32'h210);
        idle(4);
        issue(mk(FU_JAL,    FN_ADD, 32'hFFFF_FFFC, 32'd8, 5'd1, 1'b1), 32'd0, 32'd0, 1, 32'h0, 1, 32'h4);
        idle(4);
        issue(mk(FU_BRANCH, FN_LT,  32'h300, 32'hFFFF_FFF8, 5'd0, 1'b0), 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1, 32'h2F8);
        idle(4);

        // Downstream stall for 3 cycles against a continuous stream.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    issue(mk(FU_ALUI, FN_ADD, 32'h500 + 32'(4 * i), 32'd100, 5'(10 + i), 1'b1),
                          32'(i), 32'd0, 1, 32'(100 + i), 0, 0);
                end
                bus.id_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                bus.ex_ready = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                chk("stall_hold_valid", bus.ex_valid, 1);
                chk("stall_hold_res", bus.ex_res, 32'd100);
                chk("stall_id_ready", bus.id_ready, 0);
                @(negedge clk);
                bus.ex_ready = 1'b1;
            end
        join
        idle(6);

        // Flush with E1 and E2 both occupied and a taken BNE in E1.
        bus.ex_ready = 1'b0;
        issue(mk(FU_ALUI,   FN_ADD, 32'h600, 32'd1,  5'd1, 1'b1), 32'd1, 32'd0, 0, 32'd0, 0, 0);
        issue(mk(FU_BRANCH, FN_NE,  32'h604, 32'h40, 5'd0, 1'b0), 32'd1, 32'd2, 0, 32'd0, 0, 0);
        bus.id_valid = 1'b0;
        flush = 1'b1;
        #1 chk("flush1_id_ready", bus.id_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush1_ex_valid", bus.ex_valid, 0);
        chk("flush1_redirect", redirect_valid, 0);
        chk("flush1_resume", bus.id_ready, 1);
        bus.ex_ready = 1'b1;
        idle(2);

        // Flush in the same cycle a taken BNE leaves E1 suppresses the redirect.
        issue(mk(FU_BRANCH, FN_NE, 32'h640, 32'h40, 5'd0, 1'b0), 32'd1, 32'd2, 0, 32'd0, 0, 0);
        bus.id_valid = 1'b0;
        flush = 1'b1;
        #1 chk("flush2_id_ready", bus.id_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush2_redirect", redirect_valid, 0);
        chk("flush2_ex_valid", bus.ex_valid, 0);
        idle(3);

        // Reset mid-stream, then normal latency for the first new uop.
        bus.ex_ready = 1'b0;
        issue(mk(FU_ALUI, FN_ADD, 32'h680, 32'd1, 5'd1, 1'b1), 32'd1, 32'd0, 0, 32'd0, 0, 0);
        issue(mk(FU_ALUI, FN_ADD, 32'h684, 32'd1, 5'd2, 1'b1), 32'd2, 32'd0, 0, 32'd0, 0, 0);
        bus.id_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_ex_valid", bus.ex_valid, 0);
        chk("rst2_redirect", redirect_valid, 0);
        chk("rst2_ex_res", bus.ex_res, 0);
        chk("rst2_rd_wen", bus.ex_rd_wen, 0);
        chk("rst2_id_ready", bus.id_ready, 1);
        bus.ex_ready = 1'b1;
        @(negedge clk);
        issue(mk(FU_ALUI, FN_ADD, 32'h700, 32'd1, 5'd4, 1'b1), 32'h7FFF_FFFF, 32'd0, 1, 32'h8000_0000, 0, 0);
        bus.id_valid = 1'b0;
        #1 chk("rst2_lat_1cyc", bus.ex_valid, 0);
        @(negedge clk);
        #1;
        chk("rst2_lat_2cyc", bus.ex_valid, 1);
        chk("rst2_res", bus.ex_res, 32'h8000_0000);
        idle(5);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("rdr_q_drained", rdr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
